// File: rtl/commit_unit_if.sv
// Commit unit bundle: dispatch allocation, writeback completions and retirement/reclaim outputs.
// Latency: pure wiring, no storage.
// Backpressure: none in the bundle itself; dispatch must honour entry_available_bit.
//
// Ports / modports:
//   master - environment side: drives alloc_* and *_wb_*, observes pointers and commit outputs.
//   slave  - commit_unit side: the mirror of master.
interface commit_unit_if #(
    parameter int AL_SIZE = 16,
    parameter int CW_SIZE = 4,
    parameter int PR_NUM  = 64
);
    localparam int AW  = $clog2(AL_SIZE);
    localparam int PW  = $clog2(PR_NUM);
    localparam int CWW = (CW_SIZE > 1) ? $clog2(CW_SIZE) : 1;

    // dispatch side
    logic                       alloc_valid;
    logic                       alloc_uses_rw;
    logic [PW-1:0]              alloc_reclaim_reg;
    logic [AW-1:0]              youngest_inst_pointer;
    logic                       entry_available_bit;

    // completion side
    logic                       alu_wb_valid;
    logic [AW-1:0]              alu_wb_id;
    logic                       load_wb_valid;
    logic [AW-1:0]              load_wb_id;

    // retirement / free-list side
    logic                       commit_valid;
    logic [CW_SIZE-1:0]         reclaim_valid;
    logic [CW_SIZE-1:0][PW-1:0] reclaim_reg;
    logic [CWW-1:0]             last_valid_commit_idx;
    logic [PW-1:0]              free_tail_pointer;

    modport master (
        output alloc_valid,
        output alloc_uses_rw,
        output alloc_reclaim_reg,
        output alu_wb_valid,
        output alu_wb_id,
        output load_wb_valid,
        output load_wb_id,
        input  youngest_inst_pointer,
        input  entry_available_bit,
        input  commit_valid,
        input  reclaim_valid,
        input  reclaim_reg,
        input  last_valid_commit_idx,
        input  free_tail_pointer
    );

    modport slave (
        input  alloc_valid,
        input  alloc_uses_rw,
        input  alloc_reclaim_reg,
        input  alu_wb_valid,
        input  alu_wb_id,
        input  load_wb_valid,
        input  load_wb_id,
        output youngest_inst_pointer,
        output entry_available_bit,
        output commit_valid,
        output reclaim_valid,
        output reclaim_reg,
        output last_valid_commit_idx,
        output free_tail_pointer
    );
endinterface

// File: rtl/commit_unit.sv
// In-order commit unit: active list with done bits, retires up to CW_SIZE entries per edge.
// Latency: completion-to-commit >= 1 edge; commit outputs registered; free tail advances 1 edge later.
// Backpressure: entry_available_bit low when the active list is full; alloc_valid is ignored then.
//
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   cu (slave)      - alloc, writeback, commit/reclaim and free-list signals (see commit_unit_if)
//   retired_count   - 32-bit running count of retired entries, present only when the
//                     COMMIT_RETIRE_COUNT_EN macro is defined
module commit_unit #(
    parameter int AL_SIZE = 16,
    parameter int CW_SIZE = 4,
    parameter int PR_NUM  = 64
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef COMMIT_RETIRE_COUNT_EN
    output logic [31:0]   retired_count,
`endif
    commit_unit_if.slave  cu
);
    localparam int AW  = $clog2(AL_SIZE);
    localparam int OW  = AW + 1;                 // index plus color bit
    localparam int PW  = $clog2(PR_NUM);
    localparam int CWW = (CW_SIZE > 1) ? $clog2(CW_SIZE) : 1;
    localparam int NW  = $clog2(CW_SIZE + 1);    // holds a retire count 0..CW_SIZE

    // pointers: {color, index}
    logic [AW-1:0]      head_idx;
    logic               head_color;
    logic [AW-1:0]      tail_idx;
    logic               tail_color;

    // active-list storage
    logic [AL_SIZE-1:0] done_q;
    logic [AL_SIZE-1:0] uses_rw_q;
    logic [PW-1:0]      reclaim_q [AL_SIZE];

    // registered commit outputs
    logic                       commit_valid_q;
    logic [CW_SIZE-1:0]         reclaim_valid_q;
    logic [CW_SIZE-1:0][PW-1:0] reclaim_reg_q;
    logic [CWW-1:0]             last_idx_q;
    logic [PW-1:0]              free_tail_q;

    // occupancy and handshake qualification
    logic [OW-1:0] occupancy;
    logic          full;
    logic          alloc_fire;
    logic [AW-1:0] alu_off;
    logic [AW-1:0] load_off;
    logic          alu_hit;
    logic          load_hit;

    // Modular distance of the colored pointers gives 0..AL_SIZE directly.
    assign occupancy  = {tail_color, tail_idx} - {head_color, head_idx};
    assign full       = (tail_idx == head_idx) && (tail_color != head_color);
    assign alloc_fire = cu.alloc_valid && !full;

    // A writeback only counts if its entry lies inside [head, tail).
    assign alu_off  = cu.alu_wb_id  - head_idx;
    assign load_off = cu.load_wb_id - head_idx;
    assign alu_hit  = cu.alu_wb_valid  && ({1'b0, alu_off}  < occupancy);
    assign load_hit = cu.load_wb_valid && ({1'b0, load_off} < occupancy);

    // Retire scan: longest run of occupied, done entries starting at head.
    // done_q is the registered copy, so a completion arriving this cycle
    // cannot retire before the next edge.
    logic [AW-1:0] slot_idx [CW_SIZE];
    logic [NW-1:0] retire_n;
    logic          run_open;

    always_comb begin
        retire_n = '0;
        run_open = 1'b1;
        for (int i = 0; i < CW_SIZE; i++) begin
            slot_idx[i] = head_idx + AW'(i);
            if (run_open && (OW'(i) < occupancy) && done_q[slot_idx[i]]) begin
                retire_n = retire_n + NW'(1);
            end else begin
                run_open = 1'b0;
            end
        end
    end

    logic [CWW-1:0] last_idx_next;
    assign last_idx_next = (retire_n != '0) ? CWW'(retire_n - NW'(1)) : '0;

    // Registers freed by the commit currently presented on the outputs.
    logic [PW-1:0] reclaim_cnt;

    always_comb begin
        reclaim_cnt = '0;
        for (int i = 0; i < CW_SIZE; i++) begin
            if ((CWW'(i) <= last_idx_q) && reclaim_valid_q[i]) begin
                reclaim_cnt = reclaim_cnt + PW'(1);
            end
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_idx        <= '0;
            head_color      <= 1'b0;
            tail_idx        <= '0;
            tail_color      <= 1'b0;
            done_q          <= '0;
            commit_valid_q  <= 1'b0;
            reclaim_valid_q <= '0;
            reclaim_reg_q   <= '0;
            last_idx_q      <= '0;
            free_tail_q     <= '0;
        end else begin
            if (alu_hit) begin
                done_q[cu.alu_wb_id] <= 1'b1;
            end
            if (load_hit) begin
                done_q[cu.load_wb_id] <= 1'b1;
            end
            // Tail entry is unoccupied, so it never collides with a writeback hit.
            if (alloc_fire) begin
                done_q[tail_idx]         <= 1'b0;
                {tail_color, tail_idx}   <= {tail_color, tail_idx} + OW'(1);
            end

            {head_color, head_idx} <= {head_color, head_idx} + OW'(retire_n);

            commit_valid_q <= (retire_n != '0);
            last_idx_q     <= last_idx_next;
            for (int i = 0; i < CW_SIZE; i++) begin
                if (NW'(i) < retire_n) begin
                    reclaim_valid_q[i] <= uses_rw_q[slot_idx[i]];
                    reclaim_reg_q[i]   <= reclaim_q[slot_idx[i]];
                end else begin
                    reclaim_valid_q[i] <= 1'b0;
                    reclaim_reg_q[i]   <= '0;
                end
            end

            // The consumer samples free_tail_pointer while commit_valid is high,
            // so the advance lands one edge after the commit is presented.
            if (commit_valid_q) begin
                free_tail_q <= free_tail_q + reclaim_cnt;
            end
        end
    end

    // Payload storage: only meaningful while occupied, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rst_n && alloc_fire) begin
            uses_rw_q[tail_idx] <= cu.alloc_uses_rw;
            reclaim_q[tail_idx] <= cu.alloc_reclaim_reg;
        end
    end

`ifdef COMMIT_RETIRE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_count <= '0;
        end else begin
            retired_count <= retired_count + 32'(retire_n);
        end
    end
`endif

    assign cu.youngest_inst_pointer = tail_idx;
    assign cu.entry_available_bit   = !full;
    assign cu.commit_valid          = commit_valid_q;
    assign cu.reclaim_valid         = reclaim_valid_q;
    assign cu.reclaim_reg           = reclaim_reg_q;
    assign cu.last_valid_commit_idx = last_idx_q;
    assign cu.free_tail_pointer     = free_tail_q;

endmodule
